// File: rtl/register_cmd_initiator_pkg.sv
// Shared encodings for the register command initiator: register funsel codes and FSM states.
package register_cmd_initiator_pkg;

    localparam logic [1:0] FS_DEC  = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_CLR  = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StIssue  = 2'b01,
        StSample = 2'b10,
        StResp   = 2'b11
    } state_e;

endpackage

// File: rtl/register_cmd_initiator_if.sv
// Command and response handshake bundle between a sequencer (master) and the initiator (slave).
interface register_cmd_initiator_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [N-1:0]     cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic [N-1:0]     cmd_expect;
    logic             resp_valid;
    logic             resp_ready;
    logic [N-1:0]     resp_data;
    logic             resp_match;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_expect, resp_ready,
        input  cmd_ready, resp_valid, resp_data, resp_match
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_expect, resp_ready,
        output cmd_ready, resp_valid, resp_data, resp_match
    );
endinterface

// File: rtl/register.sv
// N-bit register block driven by the initiator: decrement, increment, load or clear when enabled.
module register
    import register_cmd_initiator_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [1:0]   funsel,
    input  logic [N-1:0] load,
    output logic [N-1:0] Q_out
);
    always_ff @(posedge clk) begin
        if (reset) begin
            Q_out <= '0;
        end else if (enable) begin
            unique case (funsel)
                FS_DEC:  Q_out <= Q_out - N'(1);
                FS_INC:  Q_out <= Q_out + N'(1);
                FS_LOAD: Q_out <= load;
                default: Q_out <= '0;
            endcase
        end
    end
endmodule

// File: rtl/register_cmd_initiator.sv
// Closed-loop initiator: runs one register operation for count cycles, samples Q_out, checks it
// against the expected value and returns the result over a valid/ready response.
module register_cmd_initiator
    import register_cmd_initiator_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    register_cmd_initiator_if.slave bus,
    output logic                    reg_enable,
    output logic [1:0]              reg_funsel,
    output logic [N-1:0]            reg_load,
    input  logic [N-1:0]            reg_q,
    output logic [ERR_W-1:0]        err_count
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     expect_q, expect_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             enable_q, enable_d;
    logic [1:0]       funsel_q, funsel_d;
    logic [N-1:0]     load_q, load_d;
    logic             resp_valid_q, resp_valid_d;
    logic [N-1:0]     resp_data_q, resp_data_d;
    logic             resp_match_q, resp_match_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic last_issue;
    assign last_issue = (cnt_q <= CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    state_d = (bus.cmd_count != '0) ? StIssue : StSample;
                end
            end
            StIssue:  if (last_issue) state_d = StSample;
            StSample: state_d = StResp;
            StResp:   if (bus.resp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Next values of all registered outputs; funsel/load deliberately hold between commands.
    always_comb begin
        cnt_d        = cnt_q;
        expect_d     = expect_q;
        cmd_ready_d  = cmd_ready_q;
        enable_d     = enable_q;
        funsel_d     = funsel_q;
        load_d       = load_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_match_d = resp_match_q;
        err_d        = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    cnt_d       = bus.cmd_count;
                    expect_d    = bus.cmd_expect;
                    funsel_d    = bus.cmd_op;
                    load_d      = bus.cmd_data;
                    enable_d    = (bus.cmd_count != '0);
                    cmd_ready_d = 1'b0;
                end
            end
            StIssue: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last_issue) enable_d = 1'b0;
            end
            StSample: begin
                resp_data_d  = reg_q;
                resp_match_d = (reg_q == expect_q);
                resp_valid_d = 1'b1;
            end
            StResp: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    cmd_ready_d  = 1'b1;
                    if (!resp_match_q && (err_q != {ERR_W{1'b1}})) begin
                        err_d = err_q + ERR_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            expect_q     <= '0;
            cmd_ready_q  <= 1'b1;
            enable_q     <= 1'b0;
            funsel_q     <= FS_DEC;
            load_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_match_q <= 1'b0;
            err_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            expect_q     <= expect_d;
            cmd_ready_q  <= cmd_ready_d;
            enable_q     <= enable_d;
            funsel_q     <= funsel_d;
            load_q       <= load_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_match_q <= resp_match_d;
            err_q        <= err_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_match = resp_match_q;
    assign reg_enable     = enable_q;
    assign reg_funsel     = funsel_q;
    assign reg_load       = load_q;
    assign err_count      = err_q;
endmodule

// File: tb/tb_register_cmd_initiator.sv
// Bench: initiator driving a real register; table of commands with a response scoreboard,
// plus hand sequences for reset mid-operation and reset colliding with a command.
module tb_register_cmd_initiator;
    import register_cmd_initiator_pkg::*;

    localparam int unsigned N     = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         reg_reset;
    logic         reg_enable;
    logic [1:0]   reg_funsel;
    logic [N-1:0] reg_load;
    logic [N-1:0] reg_q;
    logic [ERR_W-1:0] err_count;

    register_cmd_initiator_if #(.N(N), .CNT_W(CNT_W)) bus ();

    register_cmd_initiator #(.N(N), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .reg_enable (reg_enable),
        .reg_funsel (reg_funsel),
        .reg_load   (reg_load),
        .reg_q      (reg_q),
        .err_count  (err_count)
    );

    register #(.N(N)) u_reg (
        .clk    (clk),
        .reset  (reg_reset),
        .enable (reg_enable),
        .funsel (reg_funsel),
        .load   (reg_load),
        .Q_out  (reg_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [N-1:0]     data;
        logic [CNT_W-1:0] count;
        logic [N-1:0]     expv;
        int               delay;
        logic [N-1:0]     exp_data;
        logic             exp_match;
    } vec_t;

    typedef struct {
        logic [N-1:0] data;
        logic         match;
    } resp_t;

    vec_t  vecs[12];
    resp_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    err_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Returns at the negedge after the accept edge.
    task automatic drive_cmd(input logic [1:0] op, input logic [N-1:0] data,
                             input logic [CNT_W-1:0] count, input logic [N-1:0] expv);
        int waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); @(negedge clk); waited++;
        end
        if (waited >= 50) check("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_data   = data;
        bus.cmd_count  = count;
        bus.cmd_expect = expv;
        @(posedge clk); @(negedge clk);
        bus.cmd_valid  = 1'b0;
        bus.cmd_count  = CNT_W'($urandom);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int    cycles = 0;
        int    enables = 0;
        resp_t exp_r;
        drive_cmd(v.op, v.data, v.count, v.expv);
        sb.push_back('{data: v.exp_data, match: v.exp_match});
        while (bus.resp_valid !== 1'b1 && cycles < 40) begin
            if (reg_enable === 1'b1) enables++;
            if (bus.cmd_ready !== 1'b0) check($sformatf("busy_ready[%0d]", idx), 32'(bus.cmd_ready), 32'd0);
            @(posedge clk); @(negedge clk); cycles++;
        end
        check($sformatf("latency[%0d]", idx), 32'(cycles), 32'(v.count) + 32'd1);
        check($sformatf("enables[%0d]", idx), 32'(enables), 32'(v.count));
        for (int d = 0; d < v.delay; d++) begin
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== v.exp_data || bus.cmd_ready !== 1'b0)
                check($sformatf("hold[%0d.%0d]", idx, d),
                      {22'd0, bus.resp_valid, bus.cmd_ready, bus.resp_data},
                      {22'd0, 1'b1, 1'b0, v.exp_data});
            @(posedge clk); @(negedge clk);
        end
        if (sb.size() == 0) begin
            check($sformatf("sb_empty[%0d]", idx), 32'd0, 32'd1);
        end else begin
            exp_r = sb.pop_front();
            check($sformatf("resp_data[%0d]", idx), 32'(bus.resp_data), 32'(exp_r.data));
            check($sformatf("resp_match[%0d]", idx), 32'(bus.resp_match), 32'(exp_r.match));
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.resp_ready = 1'b0;
        if (!v.exp_match && err_exp < 255) err_exp++;
        check($sformatf("resp_clr[%0d]", idx), 32'(bus.resp_valid), 32'd0);
        check($sformatf("err_count[%0d]", idx), 32'(err_count), 32'(err_exp));
        check($sformatf("idle_hold[%0d]", idx), {22'd0, reg_funsel, reg_load},
              {22'd0, v.op, v.data});
    endtask

    initial begin
        vecs[0]  = '{FS_CLR,  8'h00, 4'd1,  8'h00, 0, 8'h00, 1'b1};
        vecs[1]  = '{FS_LOAD, 8'h01, 4'd1,  8'h01, 0, 8'h01, 1'b1};
        vecs[2]  = '{FS_INC,  8'h00, 4'd3,  8'h04, 1, 8'h04, 1'b1};
        vecs[3]  = '{FS_LOAD, 8'h00, 4'd1,  8'h00, 0, 8'h00, 1'b1};
        vecs[4]  = '{FS_DEC,  8'h00, 4'd1,  8'hFF, 0, 8'hFF, 1'b1};
        vecs[5]  = '{FS_INC,  8'h00, 4'd1,  8'h00, 2, 8'h00, 1'b1};
        vecs[6]  = '{FS_INC,  8'h00, 4'd2,  8'hAA, 5, 8'h02, 1'b0};
        vecs[7]  = '{FS_INC,  8'h00, 4'd0,  8'h02, 0, 8'h02, 1'b1};
        vecs[8]  = '{FS_LOAD, 8'h5A, 4'd3,  8'h5A, 0, 8'h5A, 1'b1};
        vecs[9]  = '{FS_CLR,  8'h00, 4'd2,  8'h00, 0, 8'h00, 1'b1};
        vecs[10] = '{FS_DEC,  8'h00, 4'd15, 8'hF1, 3, 8'hF1, 1'b1};
        vecs[11] = '{FS_LOAD, 8'h33, 4'd0,  8'h33, 0, 8'hF1, 1'b0};

        reset = 1'b1; reg_reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b11; bus.cmd_data = '0;
        bus.cmd_count = '0; bus.cmd_expect = '0; bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; reg_reset = 1'b0;

        check("rst_state", {21'd0, bus.cmd_ready, reg_enable, reg_funsel, reg_load},
              {21'd0, 1'b1, 1'b0, 2'b00, 8'h00});
        check("rst_resp", {22'd0, bus.resp_valid, bus.resp_match, bus.resp_data},
              {22'd0, 1'b0, 1'b0, 8'h00});
        check("rst_err", 32'(err_count), 32'd0);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);
        check("reg_after_table", 32'(reg_q), 32'hF1);

        // Reset lands on the third enabled edge: exactly three increments reach the register.
        drive_cmd(FS_INC, 8'h00, 4'd8, 8'h00);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        err_exp = 0;
        check("midrst_enable", 32'(reg_enable), 32'd0);
        check("midrst_ready", 32'(bus.cmd_ready), 32'd1);
        check("midrst_err", 32'(err_count), 32'd0);
        check("midrst_funsel", 32'(reg_funsel), 32'd0);
        for (int c = 0; c < 12; c++) begin
            if (bus.resp_valid !== 1'b0 || reg_enable !== 1'b0)
                check($sformatf("midrst_quiet[%0d]", c), {30'd0, bus.resp_valid, reg_enable}, 32'd0);
            @(posedge clk); @(negedge clk);
        end
        check("midrst_reg", 32'(reg_q), 32'hF4);

        // A command presented together with reset must not be accepted.
        bus.cmd_valid = 1'b1; bus.cmd_op = FS_LOAD; bus.cmd_data = 8'h77;
        bus.cmd_count = 4'd1; bus.cmd_expect = 8'h77;
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; bus.cmd_valid = 1'b0;
        check("collide_load", 32'(reg_load), 32'd0);
        check("collide_ready", 32'(bus.cmd_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            if (bus.resp_valid !== 1'b0 || reg_enable !== 1'b0)
                check($sformatf("collide_quiet[%0d]", c), {30'd0, bus.resp_valid, reg_enable}, 32'd0);
            @(posedge clk); @(negedge clk);
        end
        check("collide_reg", 32'(reg_q), 32'hF4);

        run_vec(12, '{FS_INC, 8'h00, 4'd0, 8'hF4, 0, 8'hF4, 1'b1});
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
